// File: rtl/seg7_capture.sv
// seg7_capture: recovers a 16-bit word from a multiplexed, active-low
// 7-segment display scan. Pins are synchronised, the segment pattern is
// decoded to a nibble, and a four-state frame FSM collects d0..d3 in order
// into shadow slots before committing the whole word to the output.
//
// Optional build macro: SEG7_STABLE_CHECK_EN
//   When defined, a completed frame is committed only if it matches the
//   previously completed frame (debounces a display that is mid-update).
//   When undefined, every completed frame commits.
module seg7_capture (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  led_in,
    input  logic        d0,
    input  logic        d1,
    input  logic        d2,
    input  logic        d3,
    input  logic        err_clr,
    output logic [15:0] value,
    output logic        frame_valid,
    output logic        seg_err,
    output logic        sel_err,
    output logic [1:0]  o_dbg_state
);

    // State code k+1 means "digit k accepted"; the code therefore equals the
    // index of the next digit expected in sequence.
    localparam logic [1:0] S_WAIT0 = 2'd0;
    localparam logic [1:0] S_GOT0  = 2'd1;
    localparam logic [1:0] S_GOT1  = 2'd2;
    localparam logic [1:0] S_GOT2  = 2'd3;

    logic [6:0]  r_led_s1;
    logic [6:0]  r_led_s2;
    logic [3:0]  r_sel_s1;
    logic [3:0]  r_sel_s2;
    logic [1:0]  r_state;
    logic [15:0] r_shadow;
    logic [15:0] r_value;
    logic        r_frame_valid;
    logic        r_seg_err;
    logic        r_sel_err;

    logic [3:0]  w_sel_pins;
    logic [3:0]  w_nib;
    logic        w_known;
    logic        w_sel_valid;
    logic [1:0]  w_sel_idx;
    logic [1:0]  w_state_nxt;
    logic        w_store;
    logic        w_frame_done;
    logic        w_seg_set;
    logic        w_sel_set;
    logic [15:0] w_shadow_nxt;
    logic [15:0] w_frame_word;
    logic        w_commit;

    assign w_sel_pins = {d3, d2, d1, d0};

    // Two-flop synchroniser for the asynchronous display pins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_led_s1 <= 7'd0;
            r_led_s2 <= 7'd0;
            r_sel_s1 <= 4'd0;
            r_sel_s2 <= 4'd0;
        end else begin
            r_led_s1 <= led_in;
            r_led_s2 <= r_led_s1;
            r_sel_s1 <= w_sel_pins;
            r_sel_s2 <= r_sel_s1;
        end
    end

    // Segment decode (active-low, bit6 = a .. bit0 = g). B and D are drawn
    // identically to 8 and 0 on this display, so they can never be decoded.
    always_comb begin
        w_nib   = 4'h0;
        w_known = 1'b1;
        case (r_led_s2)
            7'b0000001: w_nib = 4'h0;
            7'b1001111: w_nib = 4'h1;
            7'b0010010: w_nib = 4'h2;
            7'b0000110: w_nib = 4'h3;
            7'b1001100: w_nib = 4'h4;
            7'b0100100: w_nib = 4'h5;
            7'b0100000: w_nib = 4'h6;
            7'b0001111: w_nib = 4'h7;
            7'b0000000: w_nib = 4'h8;
            7'b0000100: w_nib = 4'h9;
            7'b0001000: w_nib = 4'hA;
            7'b0110001: w_nib = 4'hC;
            7'b0110000: w_nib = 4'hE;
            7'b0111000: w_nib = 4'hF;
            default:    w_known = 1'b0;
        endcase
    end

    // Select decode: a sample is usable only when exactly one digit is lit.
    always_comb begin
        w_sel_valid = 1'b1;
        w_sel_idx   = 2'd0;
        case (r_sel_s2)
            4'b0001: w_sel_idx = 2'd0;
            4'b0010: w_sel_idx = 2'd1;
            4'b0100: w_sel_idx = 2'd2;
            4'b1000: w_sel_idx = 2'd3;
            default: w_sel_valid = 1'b0;
        endcase
    end

    // Frame FSM next-state: in-order advance, repeat-overwrite, restart on d0.
    always_comb begin
        w_state_nxt  = r_state;
        w_store      = 1'b0;
        w_frame_done = 1'b0;
        w_seg_set    = 1'b0;
        w_sel_set    = 1'b0;
        if (!w_sel_valid) begin
            // Ambiguous sample: ignore it entirely, just flag it.
            w_sel_set = 1'b1;
        end else if (!w_known) begin
            w_seg_set   = 1'b1;
            w_state_nxt = S_WAIT0;
        end else if (w_sel_idx == r_state) begin
            w_store = 1'b1;
            if (r_state == S_GOT2) begin
                w_frame_done = 1'b1;
                w_state_nxt  = S_WAIT0;
            end else begin
                w_state_nxt = r_state + 2'd1;
            end
        end else if ((r_state != S_WAIT0) && (w_sel_idx == r_state - 2'd1)) begin
            // Slow scanner still showing the last digit: refresh its slot.
            w_store = 1'b1;
        end else if (w_sel_idx == 2'd0) begin
            w_store     = 1'b1;
            w_state_nxt = S_GOT0;
        end else begin
            w_state_nxt = S_WAIT0;
        end
    end

    // Shadow slot write for the currently selected digit.
    always_comb begin
        w_shadow_nxt = r_shadow;
        if (w_store) begin
            w_shadow_nxt[{w_sel_idx, 2'b00} +: 4] = w_nib;
        end
    end

    // Slot 3 is written in the same cycle as the commit, so take it live.
    assign w_frame_word = {w_nib, r_shadow[11:0]};

    // FSM state and shadow slots.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_WAIT0;
            r_shadow <= 16'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_shadow <= w_shadow_nxt;
        end
    end

`ifdef SEG7_STABLE_CHECK_EN
    logic [15:0] r_cmp;

    assign w_commit = w_frame_done && (w_frame_word == r_cmp);

    // Remember the last completed frame; a differing frame replaces it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cmp <= 16'd0;
        end else if (w_frame_done && (w_frame_word != r_cmp)) begin
            r_cmp <= w_frame_word;
        end
    end
`else
    assign w_commit = w_frame_done;
`endif

    // Committed word and its one-cycle strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_value       <= 16'd0;
            r_frame_valid <= 1'b0;
        end else begin
            r_frame_valid <= w_commit;
            if (w_commit) begin
                r_value <= w_frame_word;
            end
        end
    end

    // Sticky error flags; a new event wins over a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg_err <= 1'b0;
            r_sel_err <= 1'b0;
        end else begin
            r_seg_err <= w_seg_set | (r_seg_err & ~err_clr);
            r_sel_err <= w_sel_set | (r_sel_err & ~err_clr);
        end
    end

    assign value       = r_value;
    assign frame_valid = r_frame_valid;
    assign seg_err     = r_seg_err;
    assign sel_err     = r_sel_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_seg7_capture.sv
// tb_seg7_capture: directed bench for seg7_capture. Expected committed
// words are queued as frames are driven and popped when frame_valid fires.
`timescale 1ns/1ps
module tb_seg7_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  led_in;
    logic [3:0]  sel;
    logic        err_clr;
    logic [15:0] value;
    logic        frame_valid;
    logic        seg_err;
    logic        sel_err;
    logic [1:0]  dbg_state;

    int          n_asserts = 0;
    int          n_fail    = 0;
    logic [15:0] exp_q[$];
    logic [15:0] exp_value;
    logic [15:0] mon_exp;
    logic        c1, c2, c3;
`ifdef SEG7_STABLE_CHECK_EN
    logic [15:0] model_prev;
`endif

    localparam logic [6:0] LED_OFF = 7'b1111111;

    seg7_capture dut (
        .clk         (clk),
        .rst         (rst),
        .led_in      (led_in),
        .d0          (sel[0]),
        .d1          (sel[1]),
        .d2          (sel[2]),
        .d3          (sel[3]),
        .err_clr     (err_clr),
        .value       (value),
        .frame_valid (frame_valid),
        .seg_err     (seg_err),
        .sel_err     (sel_err),
        .o_dbg_state (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Display encoding as drawn by the scanner (B looks like 8, D like 0).
    function automatic logic [6:0] enc(input logic [3:0] n);
        case (n)
            4'h0: enc = 7'b0000001;
            4'h1: enc = 7'b1001111;
            4'h2: enc = 7'b0010010;
            4'h3: enc = 7'b0000110;
            4'h4: enc = 7'b1001100;
            4'h5: enc = 7'b0100100;
            4'h6: enc = 7'b0100000;
            4'h7: enc = 7'b0001111;
            4'h8: enc = 7'b0000000;
            4'h9: enc = 7'b0000100;
            4'hA: enc = 7'b0001000;
            4'hB: enc = 7'b0000000;
            4'hC: enc = 7'b0110001;
            4'hD: enc = 7'b0000001;
            4'hE: enc = 7'b0110000;
            default: enc = 7'b0111000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one pin sample; it is captured at the next rising edge.
    task automatic put(input logic [6:0] led, input logic [3:0] s, input logic clr);
        led_in  = led;
        sel     = s;
        err_clr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        put(LED_OFF, 4'b0000, 1'b0);
    endtask

    // Full in-order scan d0..d3, optionally clearing flags during d2.
    task automatic send_frame(input logic [15:0] w, input logic clr);
        for (int i = 0; i < 4; i++) begin
            put(enc(w[4*i +: 4]), 4'(1 << i), clr && (i == 2));
        end
    endtask

    // Reference model for a completed frame: decides whether it commits.
    task automatic frame_done(input logic [15:0] w, output logic c);
`ifdef SEG7_STABLE_CHECK_EN
        c = (w == model_prev);
        model_prev = w;
`else
        c = 1'b1;
`endif
        if (c) begin
            exp_q.push_back(w);
            exp_value = w;
        end
    endtask

    // Scoreboard: every strobe must match the oldest expected word.
    always @(posedge clk) begin
        #1;
        if (frame_valid === 1'b1) begin
            n_asserts++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL unexpected_commit: observed value %h expected no pulse", value);
            end
            if (exp_q.size() != 0) begin
                mon_exp = exp_q.pop_front();
                chk("commit_value", value, mon_exp);
            end
        end
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected end of test");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        led_in    = LED_OFF;
        sel       = 4'b0000;
        err_clr   = 1'b0;
        exp_value = 16'h0000;
`ifdef SEG7_STABLE_CHECK_EN
        model_prev = 16'h0000;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst_value", value, 16'h0000);
        chk("rst_fv", {15'd0, frame_valid}, 16'd0);
        chk("rst_seg_err", {15'd0, seg_err}, 16'd0);
        chk("rst_sel_err", {15'd0, sel_err}, 16'd0);
        chk("rst_state", {14'd0, dbg_state}, 16'd0);
        rst = 1'b0;

        // Back-to-back 0x1234 frames: pulse 3 edges after d3, then every 4.
        frame_done(16'h1234, c1);
        send_frame(16'h1234, 1'b0);
        frame_done(16'h1234, c2);
        put(enc(4'h4), 4'b0001, 1'b0); chk("t1_fv_e4", {15'd0, frame_valid}, 16'd0);
        put(enc(4'h3), 4'b0010, 1'b0); chk("t1_fv_e5", {15'd0, frame_valid}, {15'd0, c1});
        put(enc(4'h2), 4'b0100, 1'b0); chk("t1_fv_e6", {15'd0, frame_valid}, 16'd0);
        put(enc(4'h1), 4'b1000, 1'b0); chk("t1_fv_e7", {15'd0, frame_valid}, 16'd0);
        idle();                        chk("t1_fv_e8", {15'd0, frame_valid}, 16'd0);
        idle();                        chk("t1_fv_e9", {15'd0, frame_valid}, {15'd0, c2});
        idle();                        chk("t1_fv_e10", {15'd0, frame_valid}, 16'd0);
        chk("t1_value", value, exp_value);

        // 0xABCD as drawn decodes to 0xA8C0 with no error flags.
        frame_done(16'hA8C0, c1);
        send_frame(16'hABCD, 1'b1);
        idle(); chk("t2_fv_early", {15'd0, frame_valid}, 16'd0);
        idle(); chk("t2_fv", {15'd0, frame_valid}, {15'd0, c1});
        chk("t2_seg_err", {15'd0, seg_err}, 16'd0);
        chk("t2_sel_err", {15'd0, sel_err}, 16'd0);
        idle(); idle();
        chk("t2_value", value, exp_value);

        // d0, d1, d3 (skips d2) must not commit; full 0x5678 then does.
        put(enc(4'h1), 4'b0001, 1'b0);
        put(enc(4'h2), 4'b0010, 1'b0);
        put(enc(4'h3), 4'b1000, 1'b0);
        frame_done(16'h5678, c1);
        send_frame(16'h5678, 1'b0);
        idle(); idle(); idle();
        chk("t3_value", value, exp_value);
        chk("t3_state", {14'd0, dbg_state}, 16'd0);

        // Unknown pattern on d2: seg_err set, frame dropped, err_clr clears.
        put(enc(4'h1), 4'b0001, 1'b0);
        put(enc(4'h2), 4'b0010, 1'b0);
        put(LED_OFF,   4'b0100, 1'b0);
        put(enc(4'h4), 4'b1000, 1'b0);
        chk("t4_seg_err_pre", {15'd0, seg_err}, 16'd0);
        idle();
        chk("t4_seg_err_set", {15'd0, seg_err}, 16'd1);
        chk("t4_state_drop", {14'd0, dbg_state}, 16'd0);
        idle();
        chk("t4_state_d3", {14'd0, dbg_state}, 16'd0);
        chk("t4_fv", {15'd0, frame_valid}, 16'd0);
        put(LED_OFF, 4'b0000, 1'b1);
        chk("t4_seg_err_clr", {15'd0, seg_err}, 16'd0);
        chk("t4_value_hold", value, exp_value);

        // d1+d2 together: sel_err, state held, sample ignored; frame 0x3219.
        frame_done(16'h3219, c1);
        put(enc(4'h9), 4'b0001, 1'b0);
        put(enc(4'h0), 4'b0110, 1'b0);
        put(enc(4'h1), 4'b0010, 1'b1);
        chk("t5_state_got0", {14'd0, dbg_state}, 16'd1);
        chk("t5_sel_err_clr", {15'd0, sel_err}, 16'd0);
        put(enc(4'h2), 4'b0100, 1'b0);
        chk("t5_state_held", {14'd0, dbg_state}, 16'd1);
        chk("t5_sel_err_set", {15'd0, sel_err}, 16'd1);
        put(enc(4'h3), 4'b1000, 1'b0);
        chk("t5_state_got1", {14'd0, dbg_state}, 16'd2);
        idle();
        chk("t5_state_got2", {14'd0, dbg_state}, 16'd3);
        chk("t5_fv_early", {15'd0, frame_valid}, 16'd0);
        idle();
        chk("t5_fv", {15'd0, frame_valid}, {15'd0, c1});
        chk("t5_state_end", {14'd0, dbg_state}, 16'd0);
        idle();

        // Reset mid-frame: all outputs clear; d1..d3 alone cannot commit.
        put(enc(4'h1), 4'b0001, 1'b0);
        put(enc(4'h2), 4'b0010, 1'b0);
        put(enc(4'h3), 4'b0100, 1'b0);
        chk("t6_state_mid", {14'd0, dbg_state}, 16'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_value", value, 16'h0000);
        chk("t6_rst_fv", {15'd0, frame_valid}, 16'd0);
        chk("t6_rst_seg_err", {15'd0, seg_err}, 16'd0);
        chk("t6_rst_sel_err", {15'd0, sel_err}, 16'd0);
        chk("t6_rst_state", {14'd0, dbg_state}, 16'd0);
        exp_value = 16'h0000;
`ifdef SEG7_STABLE_CHECK_EN
        model_prev = 16'h0000;
`endif
        led_in = LED_OFF;
        sel    = 4'b0000;
        @(posedge clk);
        #1;
        rst = 1'b0;
        put(enc(4'h5), 4'b0010, 1'b0);
        put(enc(4'h6), 4'b0100, 1'b0);
        put(enc(4'h7), 4'b1000, 1'b0);
        idle(); idle(); idle();
        chk("t6_state_no_d0", {14'd0, dbg_state}, 16'd0);
        chk("t6_value_no_d0", value, 16'h0000);
        frame_done(16'h9876, c1);
        send_frame(16'h9876, 1'b0);
        idle(); idle();
        chk("t6_fv", {15'd0, frame_valid}, {15'd0, c1});
        idle();
        chk("t6_value", value, exp_value);

        // Frames 0x1111, 0x2222, 0x2222 back to back.
        frame_done(16'h1111, c1);
        frame_done(16'h2222, c2);
        frame_done(16'h2222, c3);
        send_frame(16'h1111, 1'b0);
        send_frame(16'h2222, 1'b0);
        send_frame(16'h2222, 1'b0);
        idle(); idle(); idle();
        chk("t7_value", value, 16'h2222);

        idle(); idle();
        chk("pending_commits", 16'(exp_q.size()), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
